// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its test environment.
package apb_pkg;

  // Requester transfer phases: idle, APB SETUP, APB ACCESS, response held for consumer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  // Default bus widths.
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Read data a freshly reset slave returns for locations never written.
  localparam logic [31:0] APB_RESET_PRDATA = 32'hFEDC_BA98;

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between one requester and one completer.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int addrWidth = APB_ADDR_W,
  parameter int dataWidth = APB_DATA_W
);

  logic [addrWidth-1:0] paddr;
  logic                 pwrite;
  logic                 psel;
  logic                 penable;
  logic [dataWidth-1:0] pwdata;
  logic [dataWidth-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  // Requester side drives the request, samples the completion.
  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  // Completer side samples the request, drives the completion.
  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master.sv
// APB requester: converts a valid/ready command into one SETUP+ACCESS transfer and
// returns the completion (read data, slave error, timeout) on a valid/ready response.
// At most one transfer is in flight; psel always drops between transfers.
module apb_master
  import apb_pkg::*;
#(
  parameter int addrWidth = APB_ADDR_W,
  parameter int dataWidth = APB_DATA_W,
  parameter int TIMEOUT   = 16
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  // command channel
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  // APB bus
  apb_master_if.master         apb
);

  // Counter must hold 0..TIMEOUT; keep at least one bit when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  apb_mst_state_t       state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [addrWidth-1:0] paddr_reg;
  logic [dataWidth-1:0] pwdata_reg;
  logic                 pwrite_reg;
  logic                 psel_reg;
  logic                 penable_reg;
  logic                 rsp_valid_reg;
  logic [dataWidth-1:0] rsp_rdata_reg;
  logic                 rsp_err_reg;
  logic                 rsp_timeout_reg;

  // Only the idle state can take a new command.
  assign cmd_ready = (state_reg == IDLE);

  assign apb.paddr   = paddr_reg;
  assign apb.pwrite  = pwrite_reg;
  assign apb.psel    = psel_reg;
  assign apb.penable = penable_reg;
  assign apb.pwdata  = pwdata_reg;

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pwrite_reg      <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            paddr_reg   <= cmd_addr;
            pwrite_reg  <= cmd_write;
            // reads leave the last write data on the bus untouched
            if (cmd_write) begin
              pwdata_reg <= cmd_wdata;
            end
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            state_reg   <= SETUP;
          end
        end

        SETUP: begin
          penable_reg <= 1'b1;
          cnt_reg     <= '0;
          state_reg   <= ACCESS;
        end

        ACCESS: begin
          if (apb.pready) begin
            // normal completion takes priority over a coincident timeout
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= apb.pslverr;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= pwrite_reg ? '0 : apb.prdata;
            state_reg       <= RESP;
          end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
            // slave never answered: abandon the transfer and report it
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_rdata_reg   <= '0;
            state_reg       <= RESP;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small behavioural APB completer (memory,
// programmable wait states, stuck-low pready and forced pslverr).
module tb_apb_master;
  import apb_pkg::*;

  logic        pclk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int checks = 0;
  int passes = 0;

  apb_master_if #(.addrWidth(32), .dataWidth(32)) apb ();

  apb_master #(.addrWidth(32), .dataWidth(32), .TIMEOUT(16)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // behavioural completer
  logic [31:0] mem [0:63];
  int          wait_cycles = 0;
  int          acc_cnt = 0;
  bit          stuck_low = 1'b0;
  bit          err_flag = 1'b0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = APB_RESET_PRDATA;
    mem[8] = 32'h1234_5678;  // address 0x20
  end

  assign apb.prdata  = mem[apb.paddr[7:2]];
  assign apb.pready  = stuck_low ? 1'b0 : (acc_cnt >= wait_cycles);
  assign apb.pslverr = err_flag;

  always @(posedge pclk) begin
    if (apb.psel && apb.penable) begin
      acc_cnt <= acc_cnt + 1;
      if (apb.pready && apb.pwrite) mem[apb.paddr[7:2]] <= apb.pwdata;
    end else begin
      acc_cnt <= 0;
    end
  end

  // present a command for one edge; call 1 time unit after an edge while idle
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
  endtask

  // advance until rsp_valid is seen, counting ACCESS cycles on the way
  task automatic run_until_rsp(input int budget, output int acc_cycles, output bit ok);
    acc_cycles = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid) begin ok = 1'b1; break; end
      if (apb.psel && apb.penable) acc_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b000) $display("FAIL reset_apb_ctrl: got %b want 000", {apb.psel, apb.penable, apb.pwrite}); else passes++;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) $display("FAIL reset_rsp_ctrl: got %b want 000", {rsp_valid, rsp_err, rsp_timeout}); else passes++;
    checks++; if ((apb.paddr !== 32'h0) || (apb.pwdata !== 32'h0) || (rsp_rdata !== 32'h0)) $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", apb.paddr, apb.pwdata, rsp_rdata); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passes++;
    @(negedge pclk); rst_n = 1'b1;
    @(posedge pclk); #1;
    $display("reset: released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_write_read;
    int  acc;
    bit  ok;
    // write 0x10, zero wait states, cycle-exact checks
    issue(1'b1, 32'h10, 32'hA5A5_5A5A);
    checks++; if ({apb.psel, apb.penable, cmd_ready} !== 3'b100) $display("FAIL wr_setup: psel/penable/cmd_ready=%b want 100", {apb.psel, apb.penable, cmd_ready}); else passes++;
    checks++; if ((apb.paddr !== 32'h10) || (apb.pwrite !== 1'b1) || (apb.pwdata !== 32'hA5A5_5A5A)) $display("FAIL wr_setup_bus: paddr=%h pwrite=%b pwdata=%h want 10/1/a5a55a5a", apb.paddr, apb.pwrite, apb.pwdata); else passes++;
    @(posedge pclk); #1;
    checks++; if ({apb.psel, apb.penable} !== 2'b11) $display("FAIL wr_access: psel/penable=%b want 11", {apb.psel, apb.penable}); else passes++;
    @(posedge pclk); #1;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, apb.psel} !== 4'b1000) $display("FAIL wr_rsp: valid/err/to/psel=%b want 1000", {rsp_valid, rsp_err, rsp_timeout, apb.psel}); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rdata: got %h want 0", rsp_rdata); else passes++;
    @(posedge pclk); #1;
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL wr_next_ready: cmd_ready/rsp_valid=%b want 10", {cmd_ready, rsp_valid}); else passes++;
    $display("write: addr=10 data=a5a55a5a err=%b", rsp_err);
    // read back 0x10
    issue(1'b0, 32'h10, 32'h0);
    run_until_rsp(20, acc, ok);
    checks++; if (!ok) $display("FAIL rd_no_rsp: got none want rsp_valid"); else passes++;
    checks++; if ({rsp_err, rsp_timeout} !== 2'b00 || rsp_rdata !== 32'hA5A5_5A5A) $display("FAIL rd_data: rdata=%h err=%b to=%b want a5a55a5a/0/0", rsp_rdata, rsp_err, rsp_timeout); else passes++;
    checks++; if (apb.pwdata !== 32'hA5A5_5A5A) $display("FAIL rd_pwdata_kept: got %h want a5a55a5a", apb.pwdata); else passes++;
    $display("read: addr=10 rdata=%h", rsp_rdata);
    @(posedge pclk); #1;
  endtask

  task automatic test_wait_states;
    int  acc = 0;
    bit  ok = 1'b0;
    bit  addr_ok = 1'b1;
    wait_cycles = 3;
    issue(1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid) begin ok = 1'b1; break; end
      if (apb.psel && apb.penable) acc++;
      if (apb.paddr !== 32'h20) addr_ok = 1'b0;
    end
    wait_cycles = 0;
    checks++; if (!ok) $display("FAIL ws_no_rsp: got none want rsp_valid"); else passes++;
    checks++; if (acc != 4) $display("FAIL ws_access_len: got %0d want 4", acc); else passes++;
    checks++; if (!addr_ok) $display("FAIL ws_paddr_stable: got changing paddr want 20"); else passes++;
    checks++; if (rsp_rdata !== 32'h1234_5678 || rsp_timeout !== 1'b0 || rsp_err !== 1'b0) $display("FAIL ws_rdata: rdata=%h to=%b err=%b want 12345678/0/0", rsp_rdata, rsp_timeout, rsp_err); else passes++;
    $display("wait-states: addr=20 access=%0d rdata=%h", acc, rsp_rdata);
    @(posedge pclk); #1;
  endtask

  task automatic test_timeout;
    int  acc;
    bit  ok;
    stuck_low = 1'b1;
    issue(1'b1, 32'h40, 32'hDEAD_BEEF);
    run_until_rsp(40, acc, ok);
    stuck_low = 1'b0;
    checks++; if (!ok) $display("FAIL to_no_rsp: got none want rsp_valid"); else passes++;
    checks++; if (acc != 16) $display("FAIL to_access_len: got %0d want 16", acc); else passes++;
    checks++; if ({rsp_err, rsp_timeout, apb.psel, apb.penable} !== 4'b1100 || rsp_rdata !== 32'h0) $display("FAIL to_rsp: err/to/psel/pen=%b rdata=%h want 1100/0", {rsp_err, rsp_timeout, apb.psel, apb.penable}, rsp_rdata); else passes++;
    $display("timeout: addr=40 access=%0d err=%b to=%b", acc, rsp_err, rsp_timeout);
    @(posedge pclk); #1;
  endtask

  task automatic test_slverr;
    int  acc;
    bit  ok;
    err_flag = 1'b1;
    issue(1'b0, 32'h10, 32'h0);
    run_until_rsp(20, acc, ok);
    err_flag = 1'b0;
    checks++; if (!ok) $display("FAIL se_no_rsp: got none want rsp_valid"); else passes++;
    checks++; if ({rsp_err, rsp_timeout} !== 2'b10 || rsp_rdata !== 32'hA5A5_5A5A) $display("FAIL se_rsp: err/to=%b rdata=%h want 10/a5a55a5a", {rsp_err, rsp_timeout}, rsp_rdata); else passes++;
    $display("slverr: addr=10 err=%b rdata=%h", rsp_err, rsp_rdata);
    @(posedge pclk); #1;
  endtask

  task automatic test_back_to_back;
    int  acc;
    bit  ok;
    bit  stable = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b1, 32'h50, 32'h1111_2222);
    run_until_rsp(20, acc, ok);
    checks++; if (!ok) $display("FAIL bp_no_rsp: got none want rsp_valid"); else passes++;
    // next command waits while the response is stalled
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) stable = 1'b0;
      if (cmd_ready !== 1'b0 || apb.psel !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) $display("FAIL bp_hold: valid=%b ready=%b psel=%b want 1/0/0 held", rsp_valid, cmd_ready, apb.psel); else passes++;
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    checks++; if ({cmd_ready, rsp_valid, apb.psel} !== 3'b100) $display("FAIL bp_release: ready/valid/psel=%b want 100", {cmd_ready, rsp_valid, apb.psel}); else passes++;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b100 || apb.paddr !== 32'h50) $display("FAIL bp_accept: psel/pen/pwrite=%b paddr=%h want 100/50", {apb.psel, apb.penable, apb.pwrite}, apb.paddr); else passes++;
    run_until_rsp(20, acc, ok);
    checks++; if (!ok || rsp_rdata !== 32'h1111_2222) $display("FAIL bp_readback: ok=%b rdata=%h want 1/11112222", ok, rsp_rdata); else passes++;
    $display("backpressure: addr=50 rdata=%h", rsp_rdata);
    @(posedge pclk); #1;
  endtask

  task automatic test_reset_abort;
    int  acc;
    bit  ok = 1'b0;
    bit  quiet = 1'b1;
    wait_cycles = 5;
    issue(1'b1, 32'h30, 32'hCAFE_F00D);
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk); #1;
      if (apb.psel && apb.penable) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) $display("FAIL ra_no_access: got none want ACCESS"); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({apb.psel, apb.penable, rsp_valid} !== 3'b000) $display("FAIL ra_async: psel/pen/valid=%b want 000", {apb.psel, apb.penable, rsp_valid}); else passes++;
    wait_cycles = 0;
    repeat (2) @(posedge pclk);
    @(negedge pclk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid !== 1'b0 || apb.psel !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) $display("FAIL ra_no_rsp: got activity want none after reset"); else passes++;
    issue(1'b0, 32'h30, 32'h0);
    run_until_rsp(20, acc, ok);
    checks++; if (!ok || rsp_rdata !== APB_RESET_PRDATA) $display("FAIL ra_not_committed: ok=%b rdata=%h want 1/fedcba98", ok, rsp_rdata); else passes++;
    $display("reset-abort: addr=30 rdata=%h", rsp_rdata);
    @(posedge pclk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
